// File: rtl/psshiftreg_pkg.sv
// Shared types and helpers for the psshiftreg parallel-to-serial shifter.
// Optional feature macro used across this slice: PSSHIFTREG_LAST_EN.
package psshiftreg_pkg;

  typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} psstate_t;

  // Width of a counter that must hold values 0..m inclusive.
  function automatic int cntw(input int m);
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/psshiftreg_if.sv
// Load/stream handshake bundle for psshiftreg.
// PSSHIFTREG_LAST_EN adds sout_last, the final-group marker.
interface psshiftreg_if #(
  parameter int N = 4,
  parameter int M = 2
);
  logic           load_valid;
  logic           load_ready;
  logic [M*N-1:0] din;
  logic [N-1:0]   sout;
  logic           sout_valid;
  logic           sout_ready;
  logic           busy;
`ifdef PSSHIFTREG_LAST_EN
  logic           sout_last;
`endif

  modport slave (
    input  load_valid, din, sout_ready,
    output load_ready, sout, sout_valid, busy
`ifdef PSSHIFTREG_LAST_EN
    , output sout_last
`endif
  );

  modport master (
    output load_valid, din, sout_ready,
    input  load_ready, sout, sout_valid, busy
`ifdef PSSHIFTREG_LAST_EN
    , input sout_last
`endif
  );
endinterface

// File: rtl/psshiftreg_grpcounter.sv
// Loadable down-counter tracking the groups still to be emitted for the current word.
// ld has priority over dec so a back-to-back reload restarts the count at M.
module grpcounter
  import psshiftreg_pkg::*;
#(
  parameter  int M  = 2,
  localparam int CW = cntw(M)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          ld,
  input  logic          dec,
  output logic [CW-1:0] cnt,
  output logic          last
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)   cnt <= '0;
    else if (ld)  cnt <= CW'(M);
    else if (dec) cnt <= cnt - CW'(1);
  end

  assign last = (cnt == CW'(1));

endmodule

// File: rtl/psshiftreg.sv
// Parallel-to-serial shift register: one M*N-bit word in, M N-bit groups out, MSB group first.
// Define PSSHIFTREG_LAST_EN to drive sout_last on the final group of each word.
module psshiftreg
  import psshiftreg_pkg::*;
#(
  parameter int N = 4,
  parameter int M = 2
) (
  input  logic          clk,
  input  logic          reset,
  psshiftreg_if.slave   bus
);

  localparam int W  = M * N;
  localparam int CW = cntw(M);

  psstate_t       state;
  psstate_t       state_nxt;
  logic [W-1:0]   shreg;
  logic [CW-1:0]  cnt;
  logic           last;
  logic           load;
  logic           xfer;
  logic           sout_valid;
  logic           load_ready;
  logic           busy;

  assign load = bus.load_valid & load_ready;
  assign xfer = sout_valid & bus.sout_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // A word may end and the next one start on the same edge, so load_ready
  // opens in SHIFT only while the final group is actually being taken.
  always_comb begin
    state_nxt  = state;
    sout_valid = 1'b0;
    load_ready = 1'b0;
    busy       = 1'b0;
    case (state)
      IDLE: begin
        load_ready = 1'b1;
        if (bus.load_valid) state_nxt = SHIFT;
      end
      SHIFT: begin
        sout_valid = 1'b1;
        busy       = 1'b1;
        load_ready = last & bus.sout_ready;
        if (last && bus.sout_ready && !bus.load_valid) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Shift stage: load wins over shift, stall holds the current group.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)    shreg <= '0;
    else if (load) shreg <= bus.din;
    else if (xfer) shreg <= shreg << N;
  end

  grpcounter #(.M(M)) u_grpcounter (
    .clk   (clk),
    .reset (reset),
    .ld    (load),
    .dec   (xfer),
    .cnt   (cnt),
    .last  (last)
  );

  assign bus.sout       = shreg[W-1 -: N];
  assign bus.sout_valid = sout_valid;
  assign bus.load_ready = load_ready;
  assign bus.busy       = busy;
`ifdef PSSHIFTREG_LAST_EN
  assign bus.sout_last  = sout_valid & last;
`endif

endmodule
